// File: rtl/divs_p6y3.sv
// Sequential signed divider on the 8-in/8-out tile pinout: 6-bit dividend / 3-bit divisor,
// restoring shift-subtract on magnitudes, quotient then remainder on a muxed output bus.

module divs_p6y3_step (
  input  logic [2:0] rem_i,
  input  logic       bit_i,
  input  logic [2:0] dvs_i,
  output logic [2:0] rem_o,
  output logic       q_o
);
  logic [3:0] trial;
  assign trial = {rem_i, bit_i};
  // A kept remainder is always < |B| <= 4, so modulo-8 subtraction is exact.
  assign q_o   = (trial >= {1'b0, dvs_i});
  assign rem_o = q_o ? (trial[2:0] - dvs_i) : trial[2:0];
endmodule

module divs_p6y3 (
`ifdef GL_TEST
  inout  wire        vccd1,
  inout  wire        vssd1,
`endif
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  localparam logic [2:0] S_LDA  = 3'd0;
  localparam logic [2:0] S_LDB  = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_SHQ  = 3'd3;
  localparam logic [2:0] S_SHR  = 3'd4;

  logic       clk, rst;
  logic [5:0] din;
  assign clk = io_in[0];
  assign rst = io_in[1];
  assign din = io_in[7:2];

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0] a_q, a_d;
  logic [2:0] b_q, b_d;
  logic [5:0] dvd_q, dvd_d;
  logic [2:0] rem_q, rem_d;
  logic [5:0] quo_q, quo_d;
  logic [7:0] out_q, out_d;

  logic [5:0] a_mag;
  logic [2:0] b_mag;
  logic [2:0] step_rem;
  logic       step_q;
  logic [5:0] q_res, r_res, rem_ext;

  assign a_mag   = a_q[5] ? (6'd0 - a_q) : a_q;
  assign b_mag   = b_q[2] ? (3'd0 - b_q) : b_q;
  assign rem_ext = {3'b000, rem_q};

  divs_p6y3_step u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[5]),
    .dvs_i (b_mag),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // -32/-1 needs no special case: magnitude quotient 32 wraps to 6'b100000 unsigned.
  always_comb begin
    q_res = (a_q[5] ^ b_q[2]) ? (6'd0 - quo_q) : quo_q;
    r_res = a_q[5] ? (6'd0 - rem_ext) : rem_ext;
    if (b_q == 3'd0) begin
      q_res = 6'b100000;
      r_res = a_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    out_d   = 8'h00;
    case (state_q)
      S_LDA: begin
        a_d     = din;
        state_d = S_LDB;
      end
      S_LDB: begin
        b_d     = din[2:0];
        dvd_d   = a_mag;
        rem_d   = 3'd0;
        quo_d   = 6'd0;
        cnt_d   = 3'd0;
        state_d = S_CALC;
      end
      S_CALC: begin
        dvd_d = {dvd_q[4:0], 1'b0};
        rem_d = step_rem;
        quo_d = {quo_q[4:0], step_q};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) state_d = S_SHQ;
      end
      S_SHQ: begin
        out_d   = {2'b10, q_res};
        state_d = S_SHR;
      end
      S_SHR: begin
        out_d   = {2'b11, r_res};
        state_d = S_LDA;
      end
      default: state_d = S_LDA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LDA;
      cnt_q   <= 3'd0;
      a_q     <= 6'd0;
      b_q     <= 3'd0;
      dvd_q   <= 6'd0;
      rem_q   <= 3'd0;
      quo_q   <= 6'd0;
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      out_q   <= out_d;
    end
  end

  assign io_out = out_q;
endmodule
